fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the decoder. It owns the program counter, issues one word-aligned read at a time to instruction memory over a request/grant/response handshake, and presents each fetched instruction word with its PC to the decoder through a registered output with a stall input. A redirect input from execute reloads the PC and discards any wrong-path instruction, whether it is in flight or buffered.

---
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, single-outstanding imem handshake, skid-buffered output and redirect flush
// Ports:
//   clk, reset                     clock, async active-high reset
//   imem_req/addr/gnt/rvalid/rdata instruction memory request/grant/response
//   instr, instr_pc, instr_valid   registered instruction to decoder
//   stall                          decoder back-pressure, holds the output
//   redirect, redirect_pc          restart fetch at a new PC, flushing wrong-path words
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DROP} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_req_pc, r_skid_data, r_skid_pc;
    logic        r_skid_valid;
    logic        w_gnt, w_rsp, w_free, w_load_skid;
    logic [31:0] w_redirect_pc;
    assign imem_req      = r_state == ISSUE && !r_skid_valid;
    assign imem_addr     = r_pc;
    assign w_gnt         = imem_req && imem_gnt;
    assign w_rsp         = r_state == WAIT && imem_rvalid;
    assign w_free        = !instr_valid || !stall;
    // a response lands in the skid buffer only when the output register cannot take it
    assign w_load_skid   = w_rsp && (r_skid_valid || !w_free);
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
    // a redirect while a response is still owed parks in DROP to swallow it
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = ISSUE;
            ISSUE:   w_next = w_gnt ? (redirect ? DROP : WAIT) : ISSUE;
            WAIT:    w_next = imem_rvalid ? ISSUE : (redirect ? DROP : WAIT);
            DROP:    w_next = imem_rvalid ? ISSUE : DROP;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            r_state <= w_next;
            if (w_gnt) r_req_pc <= r_pc;
            r_pc <= redirect ? w_redirect_pc : (w_gnt ? r_pc + 32'd4 : r_pc);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr        <= 32'h0000_0013;
            instr_pc     <= 32'h0;
            instr_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= 32'h0;
            r_skid_pc    <= 32'h0;
        end else if (redirect) begin
            instr_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_free) begin
                instr_valid <= r_skid_valid || w_rsp;
                if (r_skid_valid) begin
                    instr    <= r_skid_data;
                    instr_pc <= r_skid_pc;
                end else if (w_rsp) begin
                    instr    <= imem_rdata;
                    instr_pc <= r_req_pc;
                end
            end
            if (w_load_skid) begin
                r_skid_data <= imem_rdata;
                r_skid_pc   <= r_req_pc;
            end
            r_skid_valid <= w_load_skid || (r_skid_valid && !w_free);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a latency-programmable memory model
module tb_fetch_unit;
    localparam logic [31:0] K = 32'hA5A5_0000;
    logic        clk = 1'b0, reset = 1'b0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic [31:0] instr, instr_pc;
    logic        instr_valid;
    logic        stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        wrap_req, wrap_rvalid = 1'b0, wrap_valid;
    logic [31:0] wrap_addr, wrap_rdata = 32'h0, wrap_instr, wrap_ipc;
    int          lat = 1;
    int          n_checks = 0, n_pass = 0;
    logic [31:0] addr_log[$], wrap_log[$];
    logic [63:0] out_log[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req(wrap_req), .imem_addr(wrap_addr), .imem_gnt(1'b1),
        .imem_rvalid(wrap_rvalid), .imem_rdata(wrap_rdata),
        .instr(wrap_instr), .instr_pc(wrap_ipc), .instr_valid(wrap_valid),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!instr_valid && i < 20) begin
            step;
            i++;
        end
        check(tag, {31'h0, instr_valid}, 32'h1);
    endtask

    // memory: grants in the request cycle, answers lat cycles later with addr^K
    initial begin
        int          cnt;
        logic [31:0] pend, wrap_paddr;
        logic        wrap_pend;
        cnt = 0; pend = 0; wrap_paddr = 0; wrap_pend = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pend ^ K;
                end
            end
            imem_gnt = imem_req;
            if (imem_gnt) begin
                pend = imem_addr;
                cnt  = lat;
                addr_log.push_back(imem_addr);
            end
            wrap_rvalid = wrap_pend;
            wrap_rdata  = wrap_paddr ^ K;
            wrap_pend   = wrap_req;
            if (wrap_req) begin
                wrap_paddr = wrap_addr;
                wrap_log.push_back(wrap_addr);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (instr_valid && !stall) out_log.push_back({instr_pc, instr});
        end
    end

    initial begin
        #1 reset = 1'b1;
        step; step;
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h100);
        check("rst_instr", instr, 32'h13);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        reset = 1'b0;
        step;
        check("first_req", {31'h0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h100);
        check("valid_pre", {31'h0, instr_valid}, 32'h0);
        step;
        check("valid_wait", {31'h0, instr_valid}, 32'h0);
        step;
        check("first_valid", {31'h0, instr_valid}, 32'h1);
        check("first_pc", instr_pc, 32'h100);
        check("first_instr", instr, 32'hA5A5_0100);
        repeat (4) step;
        check("nreq", addr_log.size(), 32'd4);
        check("addr0", addr_log[0], 32'h100);
        check("addr1", addr_log[1], 32'h104);
        check("addr2", addr_log[2], 32'h108);
        check("nout", out_log.size(), 32'd2);
        check("out0_pc", out_log[0][63:32], 32'h100);
        check("out0_instr", out_log[0][31:0], 32'hA5A5_0100);
        check("out1_pc", out_log[1][63:32], 32'h104);
        check("out1_instr", out_log[1][31:0], 32'hA5A5_0104);
        check("wrap_addr0", wrap_log[0], 32'hFFFF_FFF8);
        check("wrap_addr1", wrap_log[1], 32'hFFFF_FFFC);
        check("wrap_addr2", wrap_log[2], 32'h0);
        check("wrap_valid", {31'h0, wrap_valid}, 32'h1);
        check("wrap_pc", wrap_ipc, 32'h0);
        check("wrap_instr", wrap_instr, 32'hA5A5_0000);
        check("pre_stall_pc", instr_pc, 32'h108);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step;
            check("stall_instr", instr, 32'hA5A5_0108);
            check("stall_valid", {31'h0, instr_valid}, 32'h1);
            check("stall_req", {31'h0, imem_req}, 32'h0);
        end
        stall = 1'b0;
        step;
        check("drain_valid", {31'h0, instr_valid}, 32'h1);
        check("drain_pc", instr_pc, 32'h10C);
        check("drain_req", {31'h0, imem_req}, 32'h1);
        check("drain_addr", imem_addr, 32'h110);
        step;
        check("nout_stall", out_log.size(), 32'd4);
        check("out2_pc", out_log[2][63:32], 32'h108);
        check("out3_pc", out_log[3][63:32], 32'h10C);
        lat = 4;
        step;
        check("pre_redir_pc", instr_pc, 32'h110);
        step;
        redirect = 1'b1;
        redirect_pc = 32'h203;
        step;
        redirect = 1'b0;
        check("drop_req", {31'h0, imem_req}, 32'h0);
        check("drop_valid", {31'h0, instr_valid}, 32'h0);
        step; step;
        check("drop_req2", {31'h0, imem_req}, 32'h0);
        step;
        check("redir_req", {31'h0, imem_req}, 32'h1);
        check("redir_addr", imem_addr, 32'h200);
        lat = 1;
        wait_valid("redir_wait");
        check("redir_pc", instr_pc, 32'h200);
        check("redir_instr", instr, 32'hA5A5_0200);
        check("gnt_req", {31'h0, imem_req}, 32'h1);
        check("gnt_addr", imem_addr, 32'h204);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        step;
        redirect = 1'b0;
        check("gdrop_req", {31'h0, imem_req}, 32'h0);
        check("gdrop_valid", {31'h0, instr_valid}, 32'h0);
        step;
        check("gnt_redir_req", {31'h0, imem_req}, 32'h1);
        check("gnt_redir_addr", imem_addr, 32'h300);
        check("gnt_redir_valid", {31'h0, instr_valid}, 32'h0);
        step;
        check("gnt_wait_valid", {31'h0, instr_valid}, 32'h0);
        step;
        check("gnt_new_valid", {31'h0, instr_valid}, 32'h1);
        check("gnt_new_pc", instr_pc, 32'h300);
        check("gnt_new_instr", instr, 32'hA5A5_0300);
        step;
        check("rv_wait_req", {31'h0, imem_req}, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h400;
        step;
        redirect = 1'b0;
        check("rv_redir_req", {31'h0, imem_req}, 32'h1);
        check("rv_redir_addr", imem_addr, 32'h400);
        check("rv_redir_valid", {31'h0, instr_valid}, 32'h0);
        lat = 3;
        step; step;
        check("rv_new_valid", {31'h0, instr_valid}, 32'h1);
        check("rv_new_pc", instr_pc, 32'h400);
        check("rv_new_instr", instr, 32'hA5A5_0400);
        lat = 1;
        step;
        reset = 1'b1;
        #1;
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        check("mid_rst_addr", imem_addr, 32'h100);
        check("mid_rst_instr", instr, 32'h13);
        check("mid_rst_pc", instr_pc, 32'h0);
        check("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
        step; step;
        reset = 1'b0;
        step;
        check("stray_valid", {31'h0, instr_valid}, 32'h0);
        check("stray_req", {31'h0, imem_req}, 32'h1);
        check("stray_addr", imem_addr, 32'h100);
        step;
        check("stray_valid2", {31'h0, instr_valid}, 32'h0);
        step;
        check("restart_valid", {31'h0, instr_valid}, 32'h1);
        check("restart_pc", instr_pc, 32'h100);
        check("restart_instr", instr, 32'hA5A5_0100);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
